sdram_scheduler: RTL



---
 rtl/sdram_scheduler.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_scheduler.sv
// Two-port SDRAM command scheduler: arbitrates a video port (A) and a CPU port (B)
// with periodic refresh, steers read data back to the requesting port.
module sdram_scheduler #(
    parameter int unsigned FREQ             = 54_000_000,
    parameter int unsigned REFRESH_INTERVAL = 780,
    parameter int unsigned FAIR_LIMIT       = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        a_req,
    input  logic        a_wr,
    input  logic [22:0] a_addr,
    input  logic [31:0] a_din32,
    input  logic [3:0]  a_wdm,
    output logic        a_ack,
    output logic [31:0] a_dout32,
    output logic        a_valid,
    input  logic        b_req,
    input  logic        b_wr,
    input  logic [22:0] b_addr,
    input  logic [31:0] b_din32,
    input  logic [3:0]  b_wdm,
    output logic        b_ack,
    output logic [31:0] b_dout32,
    output logic        b_valid,
    output logic        rd,
    output logic        wr,
    output logic        refresh,
    output logic [22:0] addr,
    output logic [31:0] din32,
    output logic [3:0]  wdm,
    input  logic        busy,
    input  logic        data_ready,
    input  logic [31:0] dout32,
    input  logic        enabled,
    output logic        refresh_overrun
);
    // Counter is wide enough for any interval up to ~15 us at FREQ.
    localparam int unsigned REF_MAX = FREQ / 66_667 + 1;
    localparam int unsigned CNT_W   = $clog2((REFRESH_INTERVAL > REF_MAX ? REFRESH_INTERVAL : REF_MAX) + 1);
    localparam int unsigned FAIR_W  = $clog2(FAIR_LIMIT + 2);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

    typedef enum logic [1:0] {IDLE, START, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FAIR_W-1:0]  fair_q, fair_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic               rd_inflight_q, rd_inflight_d;
    logic               rd_port_q, rd_port_d;
    logic               rd_q, rd_d, wr_q, wr_d, refresh_q, refresh_d;
    logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic               a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic [22:0]        addr_q, addr_d;
    logic [31:0]        din32_q, din32_d, a_dout32_q, a_dout32_d, b_dout32_q, b_dout32_d;
    logic [3:0]         wdm_q, wdm_d;

    logic go, b_turn, grant_ref, grant_a, grant_b, expire;

    always_comb begin
        go        = (state_q == IDLE) && enabled && !busy;
        b_turn    = b_req && (fair_q >= FAIR_W'(FAIR_LIMIT));
        grant_ref = go && pending_q;
        grant_a   = go && !pending_q && a_req && !b_turn;
        grant_b   = go && !pending_q && b_req && !grant_a;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fair_d        = fair_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        rd_inflight_d = rd_inflight_q;
        rd_port_d     = rd_port_q;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        refresh_d     = 1'b0;
        a_ack_d       = 1'b0;
        b_ack_d       = 1'b0;
        a_valid_d     = 1'b0;
        b_valid_d     = 1'b0;
        addr_d        = addr_q;
        din32_d       = din32_q;
        wdm_d         = wdm_q;
        a_dout32_d    = a_dout32_q;
        b_dout32_d    = b_dout32_q;
        expire        = 1'b0;

        case (state_q)
            IDLE:    if (grant_ref || grant_a || grant_b) state_d = START;
            START:   if (busy) state_d = DONE;
            DONE:    if (!busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!enabled) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            cnt_d  = RELOAD;
            expire = 1'b1;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // An expiry coinciding with the issue re-arms pending without counting as a miss.
        if (grant_ref) begin
            refresh_d = 1'b1;
            pending_d = 1'b0;
        end
        if (expire) begin
            if (pending_q && !grant_ref) overrun_d = 1'b1;
            pending_d = 1'b1;
        end

        if (data_ready && rd_inflight_q) begin
            rd_inflight_d = 1'b0;
            if (rd_port_q) begin
                b_dout32_d = dout32;
                b_valid_d  = 1'b1;
            end else begin
                a_dout32_d = dout32;
                a_valid_d  = 1'b1;
            end
        end

        if (grant_a) begin
            rd_d    = !a_wr;
            wr_d    = a_wr;
            addr_d  = a_addr;
            din32_d = a_din32;
            wdm_d   = a_wdm;
            a_ack_d = 1'b1;
            fair_d  = b_req ? fair_q + FAIR_W'(1) : '0;
            if (!a_wr) begin
                rd_inflight_d = 1'b1;
                rd_port_d     = 1'b0;
            end
        end else if (grant_b) begin
            rd_d    = !b_wr;
            wr_d    = b_wr;
            addr_d  = b_addr;
            din32_d = b_din32;
            wdm_d   = b_wdm;
            b_ack_d = 1'b1;
            fair_d  = '0;
            if (!b_wr) begin
                rd_inflight_d = 1'b1;
                rd_port_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= RELOAD;
            fair_q        <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            rd_inflight_q <= 1'b0;
            rd_port_q     <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            refresh_q     <= 1'b0;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
            a_valid_q     <= 1'b0;
            b_valid_q     <= 1'b0;
            addr_q        <= '0;
            din32_q       <= '0;
            wdm_q         <= '0;
            a_dout32_q    <= '0;
            b_dout32_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fair_q        <= fair_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            rd_inflight_q <= rd_inflight_d;
            rd_port_q     <= rd_port_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            refresh_q     <= refresh_d;
            a_ack_q       <= a_ack_d;
            b_ack_q       <= b_ack_d;
            a_valid_q     <= a_valid_d;
            b_valid_q     <= b_valid_d;
            addr_q        <= addr_d;
            din32_q       <= din32_d;
            wdm_q         <= wdm_d;
            a_dout32_q    <= a_dout32_d;
            b_dout32_q    <= b_dout32_d;
        end
    end

    assign rd              = rd_q;
    assign wr              = wr_q;
    assign refresh         = refresh_q;
    assign a_ack           = a_ack_q;
    assign b_ack           = b_ack_q;
    assign a_valid         = a_valid_q;
    assign b_valid         = b_valid_q;
    assign addr            = addr_q;
    assign din32           = din32_q;
    assign wdm             = wdm_q;
    assign a_dout32        = a_dout32_q;
    assign b_dout32        = b_dout32_q;
    assign refresh_overrun = overrun_q;

endmodule
